// File: rtl/vec_ext_pkg.sv
// Shared definitions for the streaming extremum reducer: mode encodings,
// FSM state type and the strict "a beats b" comparison used at every merge point.
package vec_ext_pkg;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } state_t;

  // Operands arrive zero-extended to 64 bits; shifting them to the top aligns the
  // real sign bit so one signed or unsigned compare serves any width up to 64.
  function automatic logic ext_better(input logic [63:0] a,
                                      input logic [63:0] b,
                                      input logic        mode,
                                      input logic        signed_cmp,
                                      input int          width);
    logic [63:0] aa;
    logic [63:0] bb;
    logic        lt;
    logic        gt;
    aa = a << (64 - width);
    bb = b << (64 - width);
    if (signed_cmp) begin
      lt = $signed(aa) < $signed(bb);
      gt = $signed(aa) > $signed(bb);
    end else begin
      lt = aa < bb;
      gt = aa > bb;
    end
    return (mode == MODE_MAX) ? gt : lt;
  endfunction

endpackage

// File: rtl/vec_ext_lane_tree.sv
// Combinational reduction of one beat's LANES elements to their extremum.
// Define VEC_EXT_INDEX_EN to also return the winning lane number.
module vec_ext_lane_tree
  import vec_ext_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  LANES      = 8,
  parameter int  SIGNED     = 1,
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                        mode_max,
  input  logic [DATA_WIDTH*LANES-1:0] lane_data,
  output logic [DATA_WIDTH-1:0]       best_val
`ifdef VEC_EXT_INDEX_EN
  ,
  output logic [LANE_W-1:0]           best_lane
`endif
);

  localparam int LVL   = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int NP    = 1 << LVL;
  localparam int NODES = 2 * NP - 1;

  logic [DATA_WIDTH*NP-1:0] padded;
  logic [DATA_WIDTH-1:0]    node_val [NODES];
  logic                     node_vld [NODES];
`ifdef VEC_EXT_INDEX_EN
  logic [LANE_W-1:0]        node_lane [NODES];
`endif

  assign padded = (DATA_WIDTH*NP)'(lane_data);

  // Heap-ordered tree: leaves at NP-1.., children of n at 2n+1 (lower lanes) and 2n+2.
  // The right child only wins when strictly better, so ties keep the lower lane.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      node_val[NP-1+i] = padded[DATA_WIDTH*i +: DATA_WIDTH];
      node_vld[NP-1+i] = (i < LANES);
`ifdef VEC_EXT_INDEX_EN
      node_lane[NP-1+i] = LANE_W'(i);
`endif
    end
    for (int n = NP - 2; n >= 0; n--) begin
      if (node_vld[2*n+2] &&
          ext_better(64'(node_val[2*n+2]), 64'(node_val[2*n+1]), mode_max,
                     SIGNED != 0, DATA_WIDTH)) begin
        node_val[n] = node_val[2*n+2];
`ifdef VEC_EXT_INDEX_EN
        node_lane[n] = node_lane[2*n+2];
`endif
      end else begin
        node_val[n] = node_val[2*n+1];
`ifdef VEC_EXT_INDEX_EN
        node_lane[n] = node_lane[2*n+1];
`endif
      end
      node_vld[n] = node_vld[2*n+1] || node_vld[2*n+2];
    end
  end

  assign best_val = node_val[0];
`ifdef VEC_EXT_INDEX_EN
  assign best_lane = node_lane[0];
`endif

endmodule

// File: rtl/vec_extremum_stream.sv
// Streaming min/max reducer over VEC_LENGTH-element vectors arriving LANES per beat.
// Define VEC_EXT_INDEX_EN to add the out_idx port and element-index tracking.
module vec_extremum_stream
  import vec_ext_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  VEC_LENGTH = 64,
  parameter int  LANES      = 8,
  parameter int  SIGNED     = 1,
  localparam int BEATS      = VEC_LENGTH / LANES,
  localparam int IDX_W      = (VEC_LENGTH > 1) ? $clog2(VEC_LENGTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mode_max,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*LANES-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data
`ifdef VEC_EXT_INDEX_EN
  ,
  output logic [IDX_W-1:0]            out_idx
`endif
);

  localparam int               CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int               LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic                  mode_q;
  logic                  eff_mode;
  logic                  accept;
  logic                  is_first;
  logic                  is_last;
  logic                  beat_wins;
  logic [DATA_WIDTH-1:0] acc_val;
  logic [DATA_WIDTH-1:0] beat_val;
  logic [DATA_WIDTH-1:0] merged_val;
`ifdef VEC_EXT_INDEX_EN
  logic [LANE_W-1:0]     beat_lane;
  logic [IDX_W-1:0]      acc_idx;
  logic [IDX_W-1:0]      beat_idx;
  logic [IDX_W-1:0]      merged_idx;
`endif

  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign is_first = (state == ST_IDLE);
  assign is_last  = (cnt == LAST_CNT);
  // The first beat reduces with the live mode input; later beats use the latched copy.
  assign eff_mode = is_first ? mode_max : mode_q;

  vec_ext_lane_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .SIGNED     (SIGNED)
  ) u_tree (
    .mode_max  (eff_mode),
    .lane_data (in_data),
    .best_val  (beat_val)
`ifdef VEC_EXT_INDEX_EN
    ,
    .best_lane (beat_lane)
`endif
  );

  // The accumulator always holds lower indices than the current beat, so strict compare keeps ties.
  assign beat_wins  = ext_better(64'(beat_val), 64'(acc_val), eff_mode, SIGNED != 0, DATA_WIDTH);
  assign merged_val = (is_first || beat_wins) ? beat_val : acc_val;
`ifdef VEC_EXT_INDEX_EN
  assign beat_idx   = IDX_W'(cnt) * IDX_W'(LANES) + IDX_W'(beat_lane);
  assign merged_idx = (is_first || beat_wins) ? beat_idx : acc_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = is_last ? ST_IDLE : ST_ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mode_q    <= MODE_MIN;
      acc_val   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (is_first) begin
          mode_q <= mode_max;
        end
        acc_val <= merged_val;
        if (is_last) begin
          cnt       <= '0;
          out_valid <= 1'b1;
          out_data  <= merged_val;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef VEC_EXT_INDEX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_idx <= '0;
      out_idx <= '0;
    end else if (accept) begin
      acc_idx <= merged_idx;
      if (is_last) begin
        out_idx <= merged_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vec_extremum_stream.sv
// Self-checking bench for vec_extremum_stream: directed table, backpressure and reset
// sequences, then randomized vectors against a reference model (signed and unsigned copies).
`timescale 1ns/1ps
module tb_vec_extremum_stream;

  localparam int DW = 16;
  localparam int VL = 8;
  localparam int LN = 4;
  localparam int IW = 3;
  localparam int NB = VL / LN;
  localparam int N_RAND = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode_max = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW*LN-1:0] in_data = '0;
  logic          in_ready_s, in_ready_u;
  logic          out_valid_s, out_valid_u;
  logic [DW-1:0] out_data_s, out_data_u;
`ifdef VEC_EXT_INDEX_EN
  logic [IW-1:0] out_idx_s, out_idx_u;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW*LN-1:0] beat0;
    logic [DW*LN-1:0] beat1;
    logic             mode0;
    logic             mode1;
    logic [DW-1:0]    exp_s;
    int               idx_s;
    logic [DW-1:0]    exp_u;
    int               idx_u;
  } vec_rec_t;

  typedef struct {
    logic [DW-1:0] val;
    int            idx;
  } res_t;

  always #5 clk = ~clk;

  vec_extremum_stream #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .LANES(LN), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .mode_max(mode_max), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s)
`ifdef VEC_EXT_INDEX_EN
    , .out_idx(out_idx_s)
`endif
  );

  vec_extremum_stream #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .LANES(LN), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .mode_max(mode_max), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u)
`ifdef VEC_EXT_INDEX_EN
    , .out_idx(out_idx_u)
`endif
  );

  function automatic logic [DW*LN-1:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic int to_int(input logic [DW-1:0] x, input bit sgn);
    return sgn ? int'($signed(x)) : int'({16'b0, x});
  endfunction

  // Reference: linear scan in element order, replacing only on a strictly better value.
  function automatic res_t model(input logic [DW-1:0] v [VL], input logic mx, input bit sgn);
    res_t r;
    int   best;
    int   cur;
    r.val = v[0];
    r.idx = 0;
    best  = to_int(v[0], sgn);
    for (int i = 1; i < VL; i++) begin
      cur = to_int(v[i], sgn);
      if (mx ? (cur > best) : (cur < best)) begin
        best  = cur;
        r.val = v[i];
        r.idx = i;
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_elem();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      4, 5:    return 16'($urandom_range(0, 3));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Sends a two-beat vector back to back and checks the result one edge after beat 1.
  task automatic applyStimulus(input vec_rec_t r, input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = r.beat0;
    mode_max  = r.mode0;
    @(posedge clk); #1;
    checkOutput({tag, "_valid_early"}, 32'(out_valid_s), 0);
    in_data  = r.beat1;
    mode_max = r.mode1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput({tag, "_valid_s"}, 32'(out_valid_s), 1);
    checkOutput({tag, "_valid_u"}, 32'(out_valid_u), 1);
    checkOutput({tag, "_data_s"}, 32'(out_data_s), 32'(r.exp_s));
    checkOutput({tag, "_data_u"}, 32'(out_data_u), 32'(r.exp_u));
`ifdef VEC_EXT_INDEX_EN
    checkOutput({tag, "_idx_s"}, 32'(out_idx_s), r.idx_s);
    checkOutput({tag, "_idx_u"}, 32'(out_idx_u), r.idx_u);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_rec_t      rows [7];
    res_t          es;
    res_t          eu;
    logic [DW-1:0] cur_vec [VL];
    logic          cur_mode;
    int            beat_no;
    int            sent;
    int            cyc;
    res_t          exp_s_q [$];
    res_t          exp_u_q [$];

    rows[0] = '{pack4(5, -3, 7, 2), pack4(9, -3, 0, 1), 1'b0, 1'b0, 16'hFFFD, 1, 16'h0000, 6};
    rows[1] = '{pack4(5, -3, 7, 2), pack4(9, -3, 0, 1), 1'b1, 1'b0, 16'h0009, 4, 16'hFFFD, 1};
    rows[2] = '{pack4('h7FFF, 'h8000, 1, 2), pack4(3, 'h8000, 4, 5), 1'b1, 1'b1, 16'h7FFF, 0, 16'h8000, 1};
    rows[3] = '{pack4('h7FFF, 'h8000, 1, 2), pack4(3, 'h8000, 4, 5), 1'b0, 1'b0, 16'h8000, 1, 16'h0001, 2};
    rows[4] = '{pack4(1, 2, 3, 4), pack4(0, 8, 8, 8), 1'b0, 1'b0, 16'h0000, 4, 16'h0000, 4};
    rows[5] = '{pack4(7, 7, 7, 7), pack4(7, 7, 7, 7), 1'b1, 1'b1, 16'h0007, 0, 16'h0007, 0};
    rows[6] = '{pack4(-1, 4, 6, 9), pack4(-8, 20, 3, 3), 1'b0, 1'b1, 16'hFFF8, 4, 16'h0003, 6};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid_s), 0);
    checkOutput("reset_in_ready", 32'(in_ready_s), 1);
    checkOutput("reset_out_data", 32'(out_data_s), 0);
`ifdef VEC_EXT_INDEX_EN
    checkOutput("reset_out_idx", 32'(out_idx_s), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(rows[i], $sformatf("row%0d", i));
    end

    // Backpressure: hold the result five cycles while a new first beat waits.
    applyStimulus(rows[0], "bp_first");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = rows[4].beat0;
    mode_max  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("bp_in_ready_low", 32'(in_ready_s), 0);
      @(posedge clk); #1;
      checkOutput("bp_valid_held", 32'(out_valid_s), 1);
      checkOutput("bp_data_stable", 32'(out_data_s), 32'(16'hFFFD));
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_in_ready_release", 32'(in_ready_s), 1);
    @(posedge clk); #1;
    checkOutput("bp_consumed", 32'(out_valid_s), 0);
    in_data = rows[4].beat1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_next_valid", 32'(out_valid_s), 1);
    checkOutput("bp_next_data", 32'(out_data_s), 0);
`ifdef VEC_EXT_INDEX_EN
    checkOutput("bp_next_idx", 32'(out_idx_s), 4);
`endif
    @(posedge clk); #1;

    // Reset between beat 0 and beat 1 discards the partial vector.
    in_valid = 1'b1;
    in_data  = pack4(-9, -9, -9, -9);
    mode_max = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", 32'(out_valid_s), 0);
    checkOutput("rst_mid_in_ready", 32'(in_ready_s), 1);
    checkOutput("rst_mid_out_data", 32'(out_data_s), 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(rows[4], "post_rst");
    @(posedge clk); #1;

    // Randomized traffic with gaps on both sides.
    beat_no = 0;
    sent    = 0;
    cyc     = 0;
    while ((sent < N_RAND || exp_s_q.size() != 0) && cyc < 20000) begin
      if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        for (int l = 0; l < LN; l++) begin
          in_data[DW*l +: DW] = rand_elem();
        end
        mode_max = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid_s && out_ready) begin
        if (exp_s_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rand_extra_result: got data %0h with no vector pending", out_data_s);
        end else begin
          es = exp_s_q.pop_front();
          eu = exp_u_q.pop_front();
          checkOutput("rand_valid_u", 32'(out_valid_u), 1);
          checkOutput("rand_data_s", 32'(out_data_s), 32'(es.val));
          checkOutput("rand_data_u", 32'(out_data_u), 32'(eu.val));
`ifdef VEC_EXT_INDEX_EN
          checkOutput("rand_idx_s", 32'(out_idx_s), es.idx);
          checkOutput("rand_idx_u", 32'(out_idx_u), eu.idx);
`endif
        end
      end
      if (in_valid && in_ready_s) begin
        for (int l = 0; l < LN; l++) begin
          cur_vec[beat_no*LN + l] = in_data[DW*l +: DW];
        end
        if (beat_no == 0) begin
          cur_mode = mode_max;
        end
        if (beat_no == NB - 1) begin
          exp_s_q.push_back(model(cur_vec, cur_mode, 1'b1));
          exp_u_q.push_back(model(cur_vec, cur_mode, 1'b0));
          beat_no = 0;
          sent++;
        end else begin
          beat_no++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("rand_pending_results", exp_s_q.size(), 0);
    checkOutput("rand_vectors_sent", sent, N_RAND);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rand_no_trailing_valid", 32'(out_valid_s), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
